sweep_stim_harness: RTL and testbench

- Synthesisable successor to the simulation-only sweep bench.
- Drives an incrementing input vector into a combinational circuit-under-test and detects when the output responds, either by a change or by settling.
- Reports each (stimulus, result, latency) tuple on a valid/ready stream, plus a total elapsed-cycle count.
- Sits between the circuit under test and the on-chip logger/host link.

---
 rtl/sweep_harness_pkg.sv | 35 +++
 rtl/sweep_settle_detect.sv | 76 +++++++
 rtl/sweep_stim_harness.sv | 206 ++++++++++++++++++++
 tb/tb_sweep_stim_harness.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_harness_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sweep_harness_pkg                                                 |
// | Brief   : Shared types, constants and helpers for the sweep stimulus harness|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package sweep_harness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam int MODE_CHANGE = 0;
    localparam int MODE_SETTLE = 1;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] data);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_settle_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sweep_settle_detect                                               |
// | Brief   : Response detector: output-change (MODE 0) or settle (MODE 1) hit  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sweep_settle_detect
    import sweep_harness_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter int MODE   = MODE_CHANGE,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             capture,
    input  logic [OUT_W-1:0] dut_out,
    output logic             hit
);

    localparam int              CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    logic [OUT_W-1:0] out_store_q, out_store_d;
    logic [OUT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] stable_nxt;
    logic             same;
    logic             change_hit;
    logic             settle_hit;

    always_comb begin
        out_store_d = out_store_q;
        prev_d      = dut_out;
        stable_d    = stable_q;
        same        = (dut_out == prev_q);
        // Clamp at SETTLE so a long-stable output never wraps the counter.
        if (!same) begin
            stable_nxt = '0;
        end else if (stable_q == SETTLE_C) begin
            stable_nxt = stable_q;
        end else begin
            stable_nxt = stable_q + CNT_W'(1);
        end

        if (clear) begin
            stable_d = '0;
        end else if (sample_en) begin
            stable_d = stable_nxt;
        end

        if (capture) begin
            out_store_d = dut_out;
        end

        change_hit = (dut_out != out_store_q);
        settle_hit = (stable_nxt == SETTLE_C);
        hit        = (MODE == MODE_SETTLE) ? settle_hit : change_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_store_q <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
        end else begin
            out_store_q <= out_store_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sweep_stim_harness.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sweep_stim_harness                                                |
// | Brief   : Sweeps an incrementing stimulus into a combinational CUT and      |
// |           streams (stimulus, response, latency) tuples. Optional MISR       |
// |           signature output enabled by SWEEP_HARNESS_MISR_EN.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sweep_stim_harness
    import sweep_harness_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int ITERATIONS = 256,
    parameter int MODE       = MODE_CHANGE,
    parameter int SETTLE     = 4,
    parameter int TIMEOUT    = 1024,
    parameter int LAT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IN_W-1:0]  res_stim,
    output logic [OUT_W-1:0] res_data,
    output logic [LAT_W-1:0] res_lat,
    output logic             res_timeout,
    output logic             busy,
    output logic             done,
    output logic [LAT_W-1:0] total_cycles
`ifdef SWEEP_HARNESS_MISR_EN
    ,
    output logic [31:0]      signature
`endif
);

    // TIMEOUT must be representable in LAT_W bits, otherwise it is never reached.
    localparam logic [LAT_W-1:0] TIMEOUT_C = LAT_W'(TIMEOUT);
    localparam logic [IN_W-1:0]  LAST_IDX  = IN_W'(ITERATIONS - 1);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] tot_q, tot_d;
    logic [IN_W-1:0]  res_stim_q, res_stim_d;
    logic [OUT_W-1:0] res_data_q, res_data_d;
    logic [LAT_W-1:0] res_lat_q, res_lat_d;
    logic             res_timeout_q, res_timeout_d;
    logic [LAT_W-1:0] total_cycles_q, total_cycles_d;
`ifdef SWEEP_HARNESS_MISR_EN
    logic [31:0]      signature_q, signature_d;
`endif

    logic [LAT_W-1:0] lat_inc;
    logic [LAT_W-1:0] tot_inc;
    logic [LAT_W-1:0] tot_inc2;
    logic             timeout_hit;
    logic             det_hit;
    logic             capture;
    logic             in_drive;
    logic             in_wait;

    assign in_drive    = (state_q == ST_DRIVE);
    assign in_wait     = (state_q == ST_WAIT);
    assign lat_inc     = LAT_W'(sat_inc(32'(lat_q), LAT_W));
    assign tot_inc     = LAT_W'(sat_inc(32'(tot_q), LAT_W));
    assign tot_inc2    = LAT_W'(sat_inc(32'(tot_inc), LAT_W));
    assign timeout_hit = (lat_inc == TIMEOUT_C);
    assign capture     = in_wait && (timeout_hit || det_hit);

    sweep_settle_detect #(
        .OUT_W  (OUT_W),
        .MODE   (MODE),
        .SETTLE (SETTLE)
    ) u_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (in_drive),
        .sample_en (in_wait),
        .capture   (capture),
        .dut_out   (dut_out),
        .hit       (det_hit)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        dut_in_d       = dut_in_q;
        lat_d          = lat_q;
        tot_d          = tot_q;
        res_stim_d     = res_stim_q;
        res_data_d     = res_data_q;
        res_lat_d      = res_lat_q;
        res_timeout_d  = res_timeout_q;
        total_cycles_d = total_cycles_q;
`ifdef SWEEP_HARNESS_MISR_EN
        signature_d    = signature_q;
`endif

        if (state_q != ST_IDLE) begin
            tot_d = tot_inc;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_DRIVE;
                    idx_d          = '0;
                    tot_d          = '0;
                    total_cycles_d = '0;
`ifdef SWEEP_HARNESS_MISR_EN
                    signature_d    = MISR_SEED;
`endif
                end
            end
            ST_DRIVE: begin
                dut_in_d = idx_q;
                lat_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                lat_d = lat_inc;
                // Timeout wins the flag whenever both conditions coincide.
                if (capture) begin
                    res_data_d    = dut_out;
                    res_stim_d    = idx_q;
                    res_lat_d     = lat_inc;
                    res_timeout_d = timeout_hit;
                    state_d       = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (res_ready) begin
`ifdef SWEEP_HARNESS_MISR_EN
                    signature_d = misr_step(signature_q, 32'(res_data_q));
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d        = ST_FINISH;
                        // Count includes this EMIT cycle and the FINISH cycle.
                        total_cycles_d = tot_inc2;
                    end else begin
                        idx_d   = idx_q + IN_W'(1);
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            dut_in_q       <= '0;
            lat_q          <= '0;
            tot_q          <= '0;
            res_stim_q     <= '0;
            res_data_q     <= '0;
            res_lat_q      <= '0;
            res_timeout_q  <= 1'b0;
            total_cycles_q <= '0;
`ifdef SWEEP_HARNESS_MISR_EN
            signature_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            dut_in_q       <= dut_in_d;
            lat_q          <= lat_d;
            tot_q          <= tot_d;
            res_stim_q     <= res_stim_d;
            res_data_q     <= res_data_d;
            res_lat_q      <= res_lat_d;
            res_timeout_q  <= res_timeout_d;
            total_cycles_q <= total_cycles_d;
`ifdef SWEEP_HARNESS_MISR_EN
            signature_q    <= signature_d;
`endif
        end
    end

    assign dut_in       = dut_in_q;
    assign res_valid    = (state_q == ST_EMIT);
    assign res_stim     = res_stim_q;
    assign res_data     = res_data_q;
    assign res_lat      = res_lat_q;
    assign res_timeout  = res_timeout_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FINISH);
    assign total_cycles = total_cycles_q;
`ifdef SWEEP_HARNESS_MISR_EN
    assign signature    = signature_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sweep_stim_harness.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sweep_stim_harness                                             |
// | Brief   : Directed table-driven bench for sweep_stim_harness (four configs) |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sweep_stim_harness;

    localparam int NU = 4;

    typedef struct {
        logic [7:0]  stim;
        logic [7:0]  data;
        logic [15:0] lat;
        logic        to;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start        [NU];
    logic        res_ready    [NU];
    logic [7:0]  dut_in       [NU];
    logic [7:0]  dut_out      [NU];
    logic        res_valid    [NU];
    logic [7:0]  res_stim     [NU];
    logic [7:0]  res_data     [NU];
    logic [15:0] res_lat      [NU];
    logic        res_timeout  [NU];
    logic        busy         [NU];
    logic        done         [NU];
    logic [15:0] total_cycles [NU];
`ifdef SWEEP_HARNESS_MISR_EN
    logic [31:0] signature    [NU];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt [NU] = '{0, 0, 0, 0};
    vec_t tbl [15];

    // Circuits under test: identity, identity visible 3 cycles after DRIVE, constant, identity.
    logic [7:0] p1a = 8'h00;
    logic [7:0] p1b = 8'h00;
    always @(posedge clk) begin
        p1a <= dut_in[1];
        p1b <= p1a;
    end
    assign dut_out[0] = dut_in[0];
    assign dut_out[1] = p1b;
    assign dut_out[2] = 8'h00;
    assign dut_out[3] = dut_in[3];

    always @(posedge clk) begin
        for (int k = 0; k < NU; k++) begin
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    sweep_stim_harness #(.IN_W(8), .OUT_W(8), .ITERATIONS(4), .MODE(0), .SETTLE(4),
                         .TIMEOUT(1024), .LAT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_in(dut_in[0]), .dut_out(dut_out[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_stim(res_stim[0]),
        .res_data(res_data[0]), .res_lat(res_lat[0]), .res_timeout(res_timeout[0]),
        .busy(busy[0]), .done(done[0]), .total_cycles(total_cycles[0])
`ifdef SWEEP_HARNESS_MISR_EN
        , .signature(signature[0])
`endif
    );

    sweep_stim_harness #(.IN_W(8), .OUT_W(8), .ITERATIONS(4), .MODE(1), .SETTLE(4),
                         .TIMEOUT(1024), .LAT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_in(dut_in[1]), .dut_out(dut_out[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_stim(res_stim[1]),
        .res_data(res_data[1]), .res_lat(res_lat[1]), .res_timeout(res_timeout[1]),
        .busy(busy[1]), .done(done[1]), .total_cycles(total_cycles[1])
`ifdef SWEEP_HARNESS_MISR_EN
        , .signature(signature[1])
`endif
    );

    sweep_stim_harness #(.IN_W(8), .OUT_W(8), .ITERATIONS(3), .MODE(0), .SETTLE(4),
                         .TIMEOUT(8), .LAT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .dut_in(dut_in[2]), .dut_out(dut_out[2]),
        .res_valid(res_valid[2]), .res_ready(res_ready[2]), .res_stim(res_stim[2]),
        .res_data(res_data[2]), .res_lat(res_lat[2]), .res_timeout(res_timeout[2]),
        .busy(busy[2]), .done(done[2]), .total_cycles(total_cycles[2])
`ifdef SWEEP_HARNESS_MISR_EN
        , .signature(signature[2])
`endif
    );

    sweep_stim_harness #(.IN_W(8), .OUT_W(8), .ITERATIONS(256), .MODE(1), .SETTLE(4),
                         .TIMEOUT(1024), .LAT_W(16)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .dut_in(dut_in[3]), .dut_out(dut_out[3]),
        .res_valid(res_valid[3]), .res_ready(res_ready[3]), .res_stim(res_stim[3]),
        .res_data(res_data[3]), .res_lat(res_lat[3]), .res_timeout(res_timeout[3]),
        .busy(busy[3]), .done(done[3]), .total_cycles(total_cycles[3])
`ifdef SWEEP_HARNESS_MISR_EN
        , .signature(signature[3])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int u, input int limit);
        int budget;
        budget = 0;
        while (!res_valid[u] && budget < limit) begin
            tick();
            budget++;
        end
        chk("valid_seen", 32'(res_valid[u]), 32'd1);
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
    endtask

    // Runs one full sweep against tbl[base..base+n-1]; stall_at < 0 means no backpressure.
    task automatic run_sweep(input int u, input int base, input int n, input int stall_at,
                             output logic [15:0] tot);
        res_ready[u] = (stall_at != 0);
        pulse_start(u);
        chk("busy_after_start", 32'(busy[u]), 32'd1);
        for (int i = 0; i < n; i++) begin
            wait_valid(u, 3000);
            chk("stim",    32'(res_stim[u]),    32'(tbl[base+i].stim));
            chk("data",    32'(res_data[u]),    32'(tbl[base+i].data));
            chk("lat",     32'(res_lat[u]),     32'(tbl[base+i].lat));
            chk("timeout", 32'(res_timeout[u]), 32'(tbl[base+i].to));
            if (i == stall_at) begin
                for (int s = 0; s < 10; s++) begin
                    tick();
                    chk("stall_valid", 32'(res_valid[u]), 32'd1);
                    chk("stall_stim",  32'(res_stim[u]),  32'(tbl[base+i].stim));
                    chk("stall_data",  32'(res_data[u]),  32'(tbl[base+i].data));
                    chk("stall_lat",   32'(res_lat[u]),   32'(tbl[base+i].lat));
                end
                res_ready[u] = 1'b1;
            end
            tick();
            chk("valid_drop", 32'(res_valid[u]), 32'd0);
            if (i + 1 == stall_at) res_ready[u] = 1'b0;
        end
        chk("done_pulse", 32'(done[u]), 32'd1);
        tot = total_cycles[u];
        tick();
        chk("done_low", 32'(done[u]), 32'd0);
        chk("idle", 32'(busy[u]), 32'd0);
        chk("total_held", 32'(total_cycles[u]), 32'(tot));
    endtask

    task automatic chk_zero(input int u);
        chk("rst_dut_in",  32'(dut_in[u]),       32'd0);
        chk("rst_valid",   32'(res_valid[u]),    32'd0);
        chk("rst_stim",    32'(res_stim[u]),     32'd0);
        chk("rst_data",    32'(res_data[u]),     32'd0);
        chk("rst_lat",     32'(res_lat[u]),      32'd0);
        chk("rst_timeout", 32'(res_timeout[u]),  32'd0);
        chk("rst_busy",    32'(busy[u]),         32'd0);
        chk("rst_done",    32'(done[u]),         32'd0);
        chk("rst_total",   32'(total_cycles[u]), 32'd0);
    endtask

    function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] shifted;
        shifted = s << 1;
        if (s[31]) shifted = shifted ^ 32'h04C1_1DB7;
        return shifted ^ d;
    endfunction

    initial begin
        logic [15:0] tot_a, tot_b1, tot_b2, tot_b3, tot_c, tot_r;
        int          dc;
        int          budget;

        // Unit A: MODE 0 identity. Stim 0 equals reset out_store -> forced by timeout.
        tbl[0]  = '{8'd0, 8'd0, 16'd1024, 1'b1};
        tbl[1]  = '{8'd1, 8'd1, 16'd1,    1'b0};
        tbl[2]  = '{8'd2, 8'd2, 16'd1,    1'b0};
        tbl[3]  = '{8'd3, 8'd3, 16'd1,    1'b0};
        // Unit C: constant 0 response, TIMEOUT 8.
        tbl[4]  = '{8'd0, 8'd0, 16'd8,    1'b1};
        tbl[5]  = '{8'd1, 8'd0, 16'd8,    1'b1};
        tbl[6]  = '{8'd2, 8'd0, 16'd8,    1'b1};
        // Unit B first sweep after reset: stim 0 never changes the output, settles at lat 4.
        tbl[7]  = '{8'd0, 8'd0, 16'd4,    1'b0};
        tbl[8]  = '{8'd1, 8'd1, 16'd7,    1'b0};
        tbl[9]  = '{8'd2, 8'd2, 16'd7,    1'b0};
        tbl[10] = '{8'd3, 8'd3, 16'd7,    1'b0};
        // Unit B later sweeps: output moves 3 -> 0 at lat 3, then 4 stable cycles.
        tbl[11] = '{8'd0, 8'd0, 16'd7,    1'b0};
        tbl[12] = '{8'd1, 8'd1, 16'd7,    1'b0};
        tbl[13] = '{8'd2, 8'd2, 16'd7,    1'b0};
        tbl[14] = '{8'd3, 8'd3, 16'd7,    1'b0};

        rst_n = 1'b0;
        for (int k = 0; k < NU; k++) begin
            start[k]     = 1'b0;
            res_ready[k] = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        chk_zero(0);
        rst_n = 1'b1;
        tick();

        // Per tuple: DRIVE + lat WAIT cycles + EMIT, plus one FINISH cycle.
        run_sweep(0, 0, 4, -1, tot_a);
        chk("a_total", 32'(tot_a), 32'd1036);
        chk("a_done_once", 32'(done_cnt[0]), 32'd1);

        run_sweep(2, 4, 3, -1, tot_c);
        chk("c_total", 32'(tot_c), 32'd31);

        run_sweep(1, 7, 4, -1, tot_b1);
        chk("b1_total", 32'(tot_b1), 32'd34);
        run_sweep(1, 11, 4, -1, tot_b2);
        chk("b2_total", 32'(tot_b2), 32'd37);
        run_sweep(1, 11, 4, 2, tot_b3);
        chk("b3_total", 32'(tot_b3), 32'd47);
        chk("stall_delta", 32'(tot_b3) - 32'(tot_b2), 32'd10);

        // Abort in WAIT of stim 2.
        dc = done_cnt[1];
        res_ready[1] = 1'b1;
        pulse_start(1);
        for (int t = 0; t < 2; t++) begin
            wait_valid(1, 3000);
            tick();
        end
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy[1]), 32'd1);
        chk("pre_rst_dut_in", 32'(dut_in[1]), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_zero(1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_done", 32'(done_cnt[1]), 32'(dc));
        run_sweep(1, 7, 4, -1, tot_r);
        chk("restart_total", 32'(tot_r), 32'd34);

        // Unit D: 256-stimulus MODE 1 sweep, first tuple 6 cycles, the rest 7 each.
        res_ready[3] = 1'b1;
        pulse_start(3);
        budget = 0;
        while (!done[3] && budget < 5000) begin
            tick();
            budget++;
        end
        chk("d_done", 32'(done[3]), 32'd1);
        chk("d_total", 32'(total_cycles[3]), 32'd1792);
        chk("d_last_stim", 32'(res_stim[3]), 32'd255);
        chk("d_last_data", 32'(res_data[3]), 32'd255);
`ifdef SWEEP_HARNESS_MISR_EN
        begin
            logic [31:0] sig;
            sig = 32'hFFFF_FFFF;
            for (int v = 0; v < 256; v++) sig = fold(sig, 32'(v));
            chk("signature", signature[3], sig);
        end
`endif
        tick();
        chk("d_idle", 32'(busy[3]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
